fifo_wr_ctrl: RTL

Write-side pointer and flag controller for the asynchronous FIFO, the write-domain counterpart of the read-side controller. It runs entirely in the write clock domain and generates the memory write address, write enable and Gray-coded write pointer for the read-domain synchronizer. It derives FULL, ALMOST_FULL, fill level and a sticky overflow flag from the 2-flop-synchronized read pointer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_gray2bin.sv | 18 +
 rtl/fifo_wr_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO read/write pointer controllers.
// Conversions take 32-bit zero-extended operands; callers truncate to pointer width.
package fifo_pkg;

  localparam int unsigned P_SIZE_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper zero bits leave the prefix-XOR result of the low bits unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned W = P_SIZE_DEF
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  logic [31:0] bin_full;

  always_comb begin
    bin_full = gray2bin(32'(gray_i));
    bin_o    = bin_full[W-1:0];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: address, Gray pointer,
// FULL / ALMOST_FULL / fill level against the synchronized read pointer, sticky OVERFLOW.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned P_SIZE       = P_SIZE_DEF,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              Winc,
  input  logic              clr_ovf,
  input  logic [P_SIZE-1:0] wq2_rptr,
  output logic [P_SIZE-2:0] waddr,
  output logic              wclken,
  output logic [P_SIZE-1:0] wptr,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic [P_SIZE-1:0] fill_level,
  output logic              OVERFLOW
);

  logic [P_SIZE-1:0] wbin_q, wbin_d;
  logic [P_SIZE-1:0] wptr_q, wptr_d;
  logic [P_SIZE-2:0] waddr_q;
  logic [P_SIZE-1:0] fill_q, fill_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic [P_SIZE-1:0] rbin;
  logic [31:0]       gray_full;

  fifo_gray2bin #(.W(P_SIZE)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  assign wclken = Winc & ~full_q;

  // FULL compares the next pointer, so it asserts on the edge that takes the last slot.
  always_comb begin
    wbin_d    = wbin_q + {{(P_SIZE-1){1'b0}}, wclken};
    gray_full = bin2gray(32'(wbin_d));
    wptr_d    = gray_full[P_SIZE-1:0];
    fill_d    = wbin_d - rbin;
    full_d    = (wptr_d == {~wq2_rptr[P_SIZE-1:P_SIZE-2], wq2_rptr[P_SIZE-3:0]});
    afull_d   = (32'(fill_d) >= AFULL_THRESH);
    ovf_d     = ovf_q;
    if (Winc && full_q) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge W_CLK) begin
    if (!W_RST) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      waddr_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      fill_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      waddr_q <= wbin_d[P_SIZE-2:0];
      full_q  <= full_d;
      afull_q <= afull_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr       = waddr_q;
  assign wptr        = wptr_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = afull_q;
  assign fill_level  = fill_q;
  assign OVERFLOW    = ovf_q;

endmodule
